// File: rtl/mux_4_rr_arbiter.sv
// Four-channel round-robin arbiter feeding a one-entry registered output stage.
// Drives the 2-bit select for the downstream 4:1 multiplexer.
module mux_4_rr_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       valid,
  output logic [3:0]       ready,
  output logic [1:0]       s,
  output logic             grant_vld,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [1:0]       y_src
);

  logic [1:0]       ptr_q;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;
  logic [1:0]       y_src_q;

  logic             load;
  logic             found;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic [WIDTH-1:0] gdata;

  // Search from the farthest offset down so the one closest to ptr wins.
  always_comb begin
    found = 1'b0;
    gidx  = ptr_q;
    idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_comb begin
    load      = !y_valid_q || y_ready;
    grant_vld = reset_n && load && found;
    ready     = 4'b0000;
    s         = 2'd0;
    if (grant_vld) begin
      ready[gidx] = 1'b1;
      s           = gidx;
    end else if (reset_n) begin
      s = ptr_q;
    end
  end

  always_comb begin
    unique case (gidx)
      2'd0:    gdata = d0;
      2'd1:    gdata = d1;
      2'd2:    gdata = d2;
      default: gdata = d3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q     <= 2'd0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= 2'd0;
    end else if (load) begin
      if (grant_vld) begin
        y_q       <= gdata;
        y_src_q   <= gidx;
        y_valid_q <= 1'b1;
        ptr_q     <= gidx + 2'd1;
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_src   = y_src_q;

endmodule

// File: doc/mux_4_rr_arbiter.md
# mux_4_rr_arbiter

Four-channel round-robin arbiter with a registered output stage. It sits directly upstream of the 4:1 data multiplexer. Each cycle it selects one of four valid/ready request channels and drives the 2-bit select `s` for that multiplexer. It captures the selected word into a one-entry output register, which presents a valid/ready stream downstream. Throughput is one word per cycle, and the arbitration is starvation-free.

## Interface
- `WIDTH`, default 4: data width of each channel and of the output.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `d0`, `d1`, `d2`, `d3`  in  WIDTH  channel data words.
- `valid`  in  4  per-channel request; bit i qualifies `di`.
- `ready`  out  4  per-channel accept, one-hot or zero. A transfer on channel i occurs when `valid[i] & ready[i]` at a rising edge.
- `s`  out  2  index of the channel granted this cycle. It is the select for the downstream 4:1 multiplexer and is combinational from `valid`, the priority pointer and `load`.
- `grant_vld`  out  1  high when `s` names an accepted channel this cycle.
- `y`  out  WIDTH  registered output word.
- `y_valid`  out  1  output register holds a word.
- `y_ready`  in  1  downstream accepts `y`. A transfer occurs when `y_valid & y_ready`.
- `y_src`  out  2  channel index the word in `y` came from.

## Operation
- Internal state:
  - `ptr` (2 bits): highest-priority channel index.
  - Output register: `y`, `y_valid`, `y_src`.
- `load = !y_valid | y_ready`. The output register can take a new word this cycle.
- Priority search:
  - Order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The grant is the first index whose `valid` bit is set.
- If `load` and any `valid`:
  - `grant_vld = 1`, `s` = grant index, `ready[grant] = 1`, other `ready` bits are 0.
  - At the edge: `y <= d[grant]`, `y_src <= grant`, `y_valid <= 1`, `ptr <= grant + 1` mod 4 (wraps 3 to 0).
- If `load` and no `valid`:
  - `ready = 0`, `grant_vld = 0`, `s = ptr`.
  - At the edge: `y_valid <= 0`; `y` and `y_src` hold; `ptr` holds.
- If `!load` (output full and stalled):
  - `ready = 0`, `grant_vld = 0`, `s = ptr`.
  - `y`, `y_valid`, `y_src` and `ptr` all hold.
- `ready` must never depend combinationally on `d*`. It depends only on `valid`, `ptr`, `y_valid` and `y_ready`.
- Downstream pop and upstream accept in the same cycle are legal. The new word replaces the popped one with no bubble.
- Upstream rule: once `valid[i]` is asserted, it must stay asserted with stable `di` until accepted. The block does not check this.
- Fairness: a continuously requesting channel is granted within 4 grants.

## Timing
- Reset (`reset_n == 0` at an edge) forces `y = 0`, `y_valid = 0`, `y_src = 0`, `ptr = 0`.
- While `reset_n == 0`, `ready = 0`, `grant_vld = 0` and `s = 0`, regardless of `valid`.
- Reset overrides any in-flight transfer. A word accepted in the reset cycle is dropped, and the bench must not count it.
- Latency: an accepted word appears on `y` with `y_valid = 1` one cycle after its accept edge.
- Throughput: with `y_ready` held at 1, there is one accept every cycle.
- Combinational paths:
  - `valid` to `ready`, `s`, `grant_vld`.
  - `y_ready` to `ready`, `s`, `grant_vld`.
  - There is no path from `y_ready` to `y` or `y_valid`.
- `y` and `y_src` may hold stale values while `y_valid = 0`; only `y_valid` qualifies them.

## Test plan
- **Reset:** assert `reset_n = 0` with `valid = 4'hF` and `y_ready = 1`.
  - Required: `ready = 0`, `y_valid = 0`, `y = 0`, `y_src = 0`.
  - On release, the first grant is channel 0.
- **Round-robin:** `valid = 4'hF`, `y_ready = 1`, `d0..d3 = 1, 2, 3, 4` (WIDTH = 4).
  - Required grants: 0, 1, 2, 3, 0 on consecutive cycles.
  - `y` follows one cycle later: 1, 2, 3, 4, 1.
  - `y_src` matches the grant index.
- **Pointer wrap and skip:** `valid = 4'b1010` after a grant on channel 3 (so `ptr = 0`).
  - Required: next grant is 1, then 3, then 1.
  - Channels 0 and 2 never get `ready`.
- **Backpressure:** after `y` is loaded with 9 from channel 2, hold `y_ready = 0` for 3 cycles with `valid = 4'hF`.
  - Required: `ready = 0`, `y = 9`, `y_valid = 1` and `ptr = 3` throughout.
  - When `y_ready` rises, the same cycle grants channel 3, and `y` changes on the next edge with no bubble.
- **Idle drain:** with `y_valid = 1` and `valid = 0`, assert `y_ready = 1` for 1 cycle.
  - Required: `y_valid = 0` next cycle, `y` held, `ptr` unchanged.
- **Reset mid-stream:** during the round-robin scenario, pulse `reset_n = 0` for 1 cycle at grant 2.
  - Required: that word is not delivered, `y_valid = 0`, and the next grant after release is channel 0.
